// File: rtl/latch_write_arbiter.sv
// Purpose: arbitrates NREQ writers onto one shared level-sensitive latch and sequences its gate (setup/open/hold).
// Latency: grant edge E -> latch_d valid at E+1, gate high E+2..E+1+OPEN_CYCLES, ack at E+2+OPEN_CYCLES.
// Backpressure: req is a held level; a request waits in IDLE until granted, one write in flight at a time.
// Optional feature: define LATCH_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module latch_write_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int OPEN_CYCLES = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  input  logic [WIDTH-1:0]         latch_q,
  output logic [WIDTH-1:0]         latch_d,
  output logic                     latch_en,
  output logic [NREQ-1:0]          ack,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     err
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(OPEN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   open_cnt;
  logic [IDW-1:0]  win;

`ifdef LATCH_ARB_RR_EN
  // Last granted requester; the search for the next winner starts just after it.
  logic [IDW-1:0]  rr_ptr;

  // Round-robin winner: first requester found scanning upward from rr_ptr+1, wrapping at NREQ.
  always_comb begin
    int              idx;
    logic [NREQ-1:0] sh;
    logic            found;
    idx   = 0;
    sh    = '0;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sh = req >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end
`else
  // Fixed-priority winner: scanning downward lets the lowest set index overwrite the others.
  always_comb begin
    logic [NREQ-1:0] sh;
    sh  = '0;
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sh = req >> i;
      if (sh[0]) win = IDW'(i);
    end
  end
`endif

  // Gate sequencer: every output is a register so nothing glitches onto the latch gate or data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      open_cnt <= '0;
      latch_d  <= '0;
      latch_en <= 1'b0;
      ack      <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
`ifdef LATCH_ARB_RR_EN
      rr_ptr   <= IDW'(NREQ - 1);
`endif
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          // req and wdata are captured only here; later changes cannot disturb the write.
          if (|req) begin
            grant_id <= win;
            latch_d  <= WIDTH'(wdata >> (int'(win) * WIDTH));
            busy     <= 1'b1;
            state    <= SETUP;
`ifdef LATCH_ARB_RR_EN
            rr_ptr   <= win;
`endif
          end
        end
        SETUP: begin
          // latch_d has had a full cycle to settle before the gate opens.
          latch_en <= 1'b1;
          open_cnt <= CW'(OPEN_CYCLES - 1);
          state    <= OPEN;
        end
        OPEN: begin
          if (open_cnt == '0) begin
            latch_en <= 1'b0;
            ack      <= NREQ'(1) << grant_id;
            state    <= HOLD;
          end else begin
            open_cnt <= open_cnt - CW'(1);
          end
        end
        HOLD: begin
          // Gate is closed and data still held, so the read-back is stable here.
          if (latch_q != latch_d) err <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Scoreboard bench for latch_write_arbiter: a transaction-level model predicts each grant,
// its data, ack cycle and the sticky error; a negedge monitor checks every DUT output.
module tb_latch_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int OC    = 1;
  localparam int IDW   = $clog2(NREQ);
  localparam int BIG   = 1 << 30;

  logic                  clock;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [WIDTH-1:0]      latch_q;
  logic [WIDTH-1:0]      latch_d;
  logic                  latch_en;
  logic [NREQ-1:0]       ack;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic                  err;

  latch_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPEN_CYCLES(OC)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .wdata    (wdata),
    .latch_q  (latch_q),
    .latch_d  (latch_d),
    .latch_en (latch_en),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural latch bank: transparent while the gate is high; optional stuck-at-zero read-back.
  logic [WIDTH-1:0] mem = '0;
  logic             stuck = 1'b0;
  always @(latch_en or latch_d) if (latch_en) mem = latch_d;
  assign latch_q = stuck ? '0 : mem;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
    int               ack_cyc;
  } txn_t;

  txn_t             exp_q[$];
  int               last_e    = -1000;
  int               next_free = 0;
  int               err_from  = BIG;
  int               m_ptr     = NREQ - 1;
  logic [WIDTH-1:0] m_d       = '0;
  int               m_gid     = 0;

  function automatic int pick(input logic [NREQ-1:0] r);
`ifdef LATCH_ARB_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      int c = (m_ptr + k) % NREQ;
      if (r[c]) return c;
    end
`else
    for (int c = 0; c < NREQ; c++) if (r[c]) return c;
`endif
    return -1;
  endfunction

  // Edge number cyc is a grant edge if the previous write has finished and someone requests.
  always @(posedge clock) begin
    txn_t t;
    int   w;
    if (!reset_n) begin
      exp_q.delete();
      last_e    = -1000;
      next_free = 0;
      err_from  = BIG;
      m_ptr     = NREQ - 1;
      m_d       = '0;
      m_gid     = 0;
    end else if (cyc >= next_free && req != '0) begin
      w         = pick(req);
      t.id      = w;
      t.data    = WIDTH'(wdata >> (w * WIDTH));
      t.ack_cyc = cyc + 2 + OC;
      exp_q.push_back(t);
      m_ptr     = w;
      m_d       = t.data;
      m_gid     = w;
      last_e    = cyc;
      next_free = cyc + OC + 3;
      if (stuck && t.data != '0 && err_from > cyc + 3 + OC) err_from = cyc + 3 + OC;
    end
    cyc = cyc + 1;
  end

  // ---------------- monitor ----------------
  logic             prev_en = 1'b0;
  logic [WIDTH-1:0] prev_d  = '0;

  always @(negedge clock) begin
    bit   exp_busy;
    bit   exp_en;
    txn_t t;
    if (reset_n) begin
      exp_busy = (cyc >= last_e + 1) && (cyc <= last_e + 2 + OC);
      exp_en   = (cyc >= last_e + 2) && (cyc <= last_e + 1 + OC);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("latch_en", 32'(latch_en), 32'(exp_en));
      chk("err", 32'(err), 32'(cyc >= err_from));
      chk("latch_d", 32'(latch_d), 32'(m_d));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      if (latch_en && prev_en) chk("latch_d_stable_open", 32'(latch_d), 32'(prev_d));
      if (exp_q.size() > 0 && cyc > exp_q[0].ack_cyc) begin
        chk("ack_on_time", 32'(cyc), 32'(exp_q[0].ack_cyc));
        void'(exp_q.pop_front());
      end
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'(0));
        end else begin
          t = exp_q.pop_front();
          chk("ack_onehot", 32'(ack), 32'(1) << t.id);
          chk("ack_cycle", 32'(cyc), 32'(t.ack_cyc));
          chk("latch_captured", 32'(mem), 32'(t.data));
        end
      end
    end
    prev_en = latch_en;
    prev_d  = latch_d;
  end

  // ---------------- stimulus ----------------
  task automatic set_slice(input int id, input logic [WIDTH-1:0] d);
    logic [NREQ*WIDTH-1:0] mask;
    mask  = {{(NREQ*WIDTH-WIDTH){1'b0}}, {WIDTH{1'b1}}} << (id * WIDTH);
    wdata = (wdata & ~mask) | ((NREQ*WIDTH)'(d) << (id * WIDTH));
  endtask

  task automatic wait_ack(input int id);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock);
      if (ack[id]) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'(1));
  endtask

  task automatic wait_en();
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock);
      if (latch_en) got = 1'b1;
    end
    chk("gate_opened", 32'(got), 32'(1));
  endtask

  task automatic do_write(input int id, input logic [WIDTH-1:0] d);
    @(negedge clock);
    set_slice(id, d);
    req[id] = 1'b1;
    wait_ack(id);
    req[id] = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] snap;
    reset_n = 1'b0;
    req     = '0;
    wdata   = '0;
    repeat (3) @(negedge clock);
    chk("rst_latch_en", 32'(latch_en), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_latch_d", 32'(latch_d), 32'(0));
    chk("rst_grant_id", 32'(grant_id), 32'(0));
    #2 reset_n = 1'b1;

    // Single write from requester 0.
    do_write(0, 8'hA5);
    repeat (2) @(negedge clock);

    // All requesting, then 1010, then only 3 (served once 1 drops).
    @(negedge clock);
    for (int j = 0; j < NREQ; j++) set_slice(j, WIDTH'(8'h10 + j));
    req = 4'b1111;
    repeat (8 * (OC + 3)) @(negedge clock);
    req = 4'b1010;
    repeat (4 * (OC + 3)) @(negedge clock);
    req = 4'b1000;
    wait_ack(3);
    req = '0;
    repeat (3) @(negedge clock);

    // Stability: change data and drop req while the gate is open.
    @(negedge clock);
    set_slice(2, 8'h5E);
    req[2] = 1'b1;
    wait_en();
    set_slice(2, 8'hFF);
    req = '0;
    repeat (8) @(negedge clock);

    // Read-back error: stuck latch, then clean writes keep err high.
    stuck = 1'b1;
    do_write(0, 8'h3C);
    @(negedge clock);
    stuck = 1'b0;
    do_write(1, 8'h5A);
    do_write(2, 8'h11);
    repeat (3) @(negedge clock);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if ($urandom_range(0, 2) == 0) req = NREQ'($urandom);
      for (int j = 0; j < NREQ; j++) set_slice(j, WIDTH'($urandom));
    end
    req = '0;
    repeat (12) @(negedge clock);

    // Reset in the middle of OPEN.
    @(negedge clock);
    set_slice(0, 8'hC3);
    req[0] = 1'b1;
    wait_en();
    req = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_latch_en", 32'(latch_en), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_ack", 32'(ack), 32'(0));
    chk("midrst_err", 32'(err), 32'(0));
    chk("midrst_latch_d", 32'(latch_d), 32'(0));
    chk("midrst_grant_id", 32'(grant_id), 32'(0));
    snap = mem;
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("latch_untouched_after_rst", 32'(mem), 32'(snap));

    // After reset requester 0 has first priority in either arbitration mode.
    @(negedge clock);
    for (int j = 0; j < NREQ; j++) set_slice(j, WIDTH'(8'h70 + j));
    req = '1;
    wait_ack(0);
    req = '0;
    repeat (12) @(negedge clock);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
